// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// traffic_pkg : lamp encodings and controller state enum
// Revision    : 1.0
// ============================================================================
package traffic_pkg;

    // Lamps are active-low {R,B,G}
    localparam logic [2:0] LED_RED   = 3'b011;
    localparam logic [2:0] LED_BLUE  = 3'b101;
    localparam logic [2:0] LED_GREEN = 3'b110;

    // STARTUP shares the low three bits with CLR_C: both are all-red phases
    // that lead straight into MAIN_G, so the 3-bit debug view stays meaningful.
    typedef enum logic [3:0] {
        MAIN_G  = 4'd0,
        MAIN_B  = 4'd1,
        CLR_A   = 4'd2,
        SIDE_G  = 4'd3,
        SIDE_B  = 4'd4,
        CLR_B   = 4'd5,
        PED     = 4'd6,
        CLR_C   = 4'd7,
        STARTUP = 4'd15
    } state_e;

endpackage
`default_nettype wire

// File: rtl/phase_timer.sv
`default_nettype none
// ============================================================================
// phase_timer : loadable 32-bit down counter, done while the count is zero
// Revision    : 1.0
// ============================================================================
module phase_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_val,
    output logic        done
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != 32'd0) begin
            count_d = count_q - 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == 32'd0);

endmodule
`default_nettype wire

// File: rtl/traffic_intersection_ctrl.sv
`default_nettype none
// ============================================================================
// traffic_intersection_ctrl : two-road intersection controller with optional
// pedestrian phase (enabled by defining TRAFFIC_PED_EN).
// Revision : 1.0
// ============================================================================
module traffic_intersection_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned MAIN_GREEN_CYC = 120_000_000,
    parameter int unsigned SIDE_GREEN_CYC = 120_000_000,
    parameter int unsigned BLUE_CYC       = 48_000_000,
    parameter int unsigned ALLRED_CYC     = 24_000_000,
    parameter int unsigned PED_CYC        = 240_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       side_req,
    input  logic       ped_req,
    output logic       ped_ack,
    output logic [2:0] main_led,
    output logic [2:0] side_led,
    output logic       ped_walk,
    output logic [2:0] phase
);

    state_e      state_q, state_d;
    logic        entry_q, entry_d;
    logic        side_lat_q, side_lat_d;
    logic [2:0]  main_led_q, main_led_d;
    logic [2:0]  side_led_q, side_led_d;
    logic [2:0]  phase_q, phase_d;
    logic [31:0] dur;
    logic        timer_done;
    logic        expire;
    logic        ped_pend;

    always_comb begin
        dur = ALLRED_CYC;
        case (state_q)
            MAIN_G:         dur = MAIN_GREEN_CYC;
            MAIN_B, SIDE_B: dur = BLUE_CYC;
            SIDE_G:         dur = SIDE_GREEN_CYC;
            PED:            dur = PED_CYC;
            default:        dur = ALLRED_CYC;
        endcase
    end

    // The timer is loaded in the first cycle of a state, so it must count
    // dur-2 further cycles; a one-cycle state expires in its entry cycle.
    phase_timer u_phase_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (entry_q),
        .load_val (dur - 32'd2),
        .done     (timer_done)
    );

    assign expire = entry_q ? (dur == 32'd1) : timer_done;

    always_comb begin
        state_d = state_q;
        case (state_q)
            STARTUP: if (expire) state_d = MAIN_G;
            MAIN_G:  if (expire && (side_req || ped_pend)) state_d = MAIN_B;
            MAIN_B:  if (expire) state_d = CLR_A;
            CLR_A:   if (expire) state_d = side_lat_q ? SIDE_G : (ped_pend ? PED : MAIN_G);
            SIDE_G:  if (expire) state_d = SIDE_B;
            SIDE_B:  if (expire) state_d = CLR_B;
            CLR_B:   if (expire) state_d = ped_pend ? PED : MAIN_G;
`ifdef TRAFFIC_PED_EN
            PED:     if (expire) state_d = CLR_C;
            CLR_C:   if (expire) state_d = MAIN_G;
`endif
            default: state_d = STARTUP;
        endcase
    end

    always_comb begin
        entry_d    = (state_d != state_q);
        side_lat_d = side_lat_q;
        if (state_d == MAIN_B && state_q != MAIN_B) side_lat_d = side_req;
        if (state_d == SIDE_G && state_q != SIDE_G) side_lat_d = 1'b0;

        main_led_d = LED_RED;
        side_led_d = LED_RED;
        case (state_d)
            MAIN_G:  main_led_d = LED_GREEN;
            MAIN_B:  main_led_d = LED_BLUE;
            SIDE_G:  side_led_d = LED_GREEN;
            SIDE_B:  side_led_d = LED_BLUE;
            default: ;
        endcase
        phase_d = state_d[2:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= STARTUP;
            entry_q    <= 1'b1;
            side_lat_q <= 1'b0;
            main_led_q <= LED_RED;
            side_led_q <= LED_RED;
            phase_q    <= 3'b111;
        end else begin
            state_q    <= state_d;
            entry_q    <= entry_d;
            side_lat_q <= side_lat_d;
            main_led_q <= main_led_d;
            side_led_q <= side_led_d;
            phase_q    <= phase_d;
        end
    end

`ifdef TRAFFIC_PED_EN
    logic ped_prev_q, ped_prev_d;
    logic ped_pend_q, ped_pend_d;
    logic ped_ack_q,  ped_ack_d;
    logic ped_walk_q, ped_walk_d;
    logic ped_rise;

    assign ped_rise = ped_req & ~ped_prev_q;

    // A new press in the same cycle PED is entered stays pending.
    always_comb begin
        ped_prev_d = ped_req;
        ped_ack_d  = ped_rise;
        ped_walk_d = (state_d == PED);
        ped_pend_d = ped_pend_q;
        if (state_d == PED && state_q != PED) ped_pend_d = 1'b0;
        if (ped_rise) ped_pend_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ped_prev_q <= 1'b0;
            ped_pend_q <= 1'b0;
            ped_ack_q  <= 1'b0;
            ped_walk_q <= 1'b0;
        end else begin
            ped_prev_q <= ped_prev_d;
            ped_pend_q <= ped_pend_d;
            ped_ack_q  <= ped_ack_d;
            ped_walk_q <= ped_walk_d;
        end
    end

    assign ped_pend = ped_pend_q;
    assign ped_ack  = ped_ack_q;
    assign ped_walk = ped_walk_q;
`else
    logic unused_ped_req;
    assign unused_ped_req = ped_req;
    assign ped_pend       = 1'b0;
    assign ped_ack        = 1'b0;
    assign ped_walk       = 1'b0;
`endif

    assign main_led = main_led_q;
    assign side_led = side_led_q;
    assign phase    = phase_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_intersection_ctrl.sv
`default_nettype none
// ============================================================================
// tb_traffic_intersection_ctrl : table-driven directed bench for the controller
// Revision : 1.0
// ============================================================================
module tb_traffic_intersection_ctrl;

    localparam logic [2:0] R = 3'b011;
    localparam logic [2:0] B = 3'b101;
    localparam logic [2:0] G = 3'b110;
    localparam logic PED_EN =
`ifdef TRAFFIC_PED_EN
        1'b1;
`else
        1'b0;
`endif

    typedef struct {
        int         n;
        logic       side;
        logic       ped;
        logic [2:0] main_e;
        logic [2:0] side_e;
        logic       walk_e;
        logic       ack_e;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       side_req = 1'b0;
    logic       ped_req = 1'b0;
    logic       ped_ack;
    logic [2:0] main_led;
    logic [2:0] side_led;
    logic       ped_walk;
    logic [2:0] phase;

    int   tests = 0;
    int   failed = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    traffic_intersection_ctrl #(
        .MAIN_GREEN_CYC (8),
        .SIDE_GREEN_CYC (6),
        .BLUE_CYC       (3),
        .ALLRED_CYC     (2),
        .PED_CYC        (5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .side_req (side_req),
        .ped_req  (ped_req),
        .ped_ack  (ped_ack),
        .main_led (main_led),
        .side_led (side_led),
        .ped_walk (ped_walk),
        .phase    (phase)
    );

    function automatic void add(int n, logic s, logic p, logic [2:0] m,
                                logic [2:0] sd, logic w, logic a);
        tbl.push_back('{n, s, p, m, sd, w, a});
    endfunction

    task automatic check_outputs(string name, int cyc, logic [2:0] m_e,
                                 logic [2:0] s_e, logic w_e, logic a_e);
        tests++;
        if (main_led !== m_e || side_led !== s_e || ped_walk !== w_e || ped_ack !== a_e) begin
            failed++;
            $display("FAIL %s cyc %0d: main=%b side=%b walk=%b ack=%b, required main=%b side=%b walk=%b ack=%b",
                     name, cyc, main_led, side_led, ped_walk, ped_ack, m_e, s_e, w_e, a_e);
        end
        tests++;
        if (main_led !== R && side_led !== R) begin
            failed++;
            $display("FAIL %s cyc %0d conflict: main=%b side=%b, required one road red",
                     name, cyc, main_led, side_led);
        end
    endtask

    // Each record row: check this cycle's outputs, then drive this cycle's inputs.
    task automatic run_table(string name);
        int cyc = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                check_outputs(name, cyc, tbl[i].main_e, tbl[i].side_e, tbl[i].walk_e, tbl[i].ack_e);
                side_req = tbl[i].side;
                ped_req  = tbl[i].ped;
                @(negedge clk);
                cyc++;
            end
        end
        tbl.delete();
    endtask

    task automatic do_reset(string name, int cycles);
        rst_n    = 1'b0;
        side_req = 1'b0;
        ped_req  = 1'b0;
        repeat (cycles) @(negedge clk);
        check_outputs(name, -1, R, R, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);

        // Reset release then idle: startup all-red, then main green held
        do_reset("reset", 3);
        add(2,   0, 0, R, R, 0, 0);
        add(100, 0, 0, G, R, 0, 0);
        run_table("idle");

        // Side request held; side latch survives side_req dropping in MAIN_B
        do_reset("reset_side", 3);
        add(2, 1, 0, R, R, 0, 0);
        add(8, 1, 0, G, R, 0, 0);
        add(3, 1, 0, B, R, 0, 0);
        add(2, 1, 0, R, R, 0, 0);
        add(6, 1, 0, R, G, 0, 0);
        add(3, 1, 0, R, B, 0, 0);
        add(2, 1, 0, R, R, 0, 0);
        add(8, 1, 0, G, R, 0, 0);
        add(3, 0, 0, B, R, 0, 0);
        add(2, 0, 0, R, R, 0, 0);
        add(6, 0, 0, R, G, 0, 0);
        add(3, 0, 0, R, B, 0, 0);
        add(2, 0, 0, R, R, 0, 0);
        add(10, 0, 0, G, R, 0, 0);
        run_table("side");

        // One-cycle pedestrian press after minimum green has elapsed
        do_reset("reset_ped", 3);
        add(2, 0, 0, R, R, 0, 0);
        add(8, 0, 0, G, R, 0, 0);
        add(1, 0, 1, G, R, 0, 0);
`ifdef TRAFFIC_PED_EN
        add(1, 0, 0, G, R, 0, 1);
        add(3, 0, 0, B, R, 0, 0);
        add(2, 0, 0, R, R, 0, 0);
        add(5, 0, 0, R, R, 1, 0);
        add(2, 0, 0, R, R, 0, 0);
        add(10, 0, 0, G, R, 0, 0);
`else
        add(30, 0, 0, G, R, 0, 0);
`endif
        run_table("ped");

        // Side and pedestrian together: side served first, then walk
        do_reset("reset_both", 3);
        add(2, 0, 0, R, R, 0, 0);
        add(1, 1, 1, G, R, 0, 0);
        add(1, 1, 0, G, R, 0, PED_EN);
        add(6, 1, 0, G, R, 0, 0);
        add(3, 0, 0, B, R, 0, 0);
        add(2, 0, 0, R, R, 0, 0);
        add(6, 0, 0, R, G, 0, 0);
        add(3, 0, 0, R, B, 0, 0);
        add(2, 0, 0, R, R, 0, 0);
`ifdef TRAFFIC_PED_EN
        add(5, 0, 0, R, R, 1, 0);
        add(2, 0, 0, R, R, 0, 0);
`endif
        add(10, 0, 0, G, R, 0, 0);
        run_table("both");

        // Reset in the middle of SIDE_G with a press pending
        do_reset("reset_mid0", 3);
        add(2, 1, 0, R, R, 0, 0);
        add(8, 1, 0, G, R, 0, 0);
        add(3, 0, 0, B, R, 0, 0);
        add(2, 0, 0, R, R, 0, 0);
        add(2, 0, 0, R, G, 0, 0);
        add(1, 0, 1, R, G, 0, 0);
        add(1, 0, 0, R, G, 0, PED_EN);
        run_table("to_side_g");
        do_reset("reset_mid", 1);
        add(2,  0, 0, R, R, 0, 0);
        add(20, 0, 0, G, R, 0, 0);
        run_table("after_mid_reset");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/traffic_intersection_ctrl.md
TRAFFIC_INTERSECTION_CTRL -- requirements
Module: traffic_intersection_ctrl

Interface
REQ-001 SHALL have parameter MAIN_GREEN_CYC, default 120_000_000, minimum main-road green time in cycles.
REQ-002 SHALL have parameter SIDE_GREEN_CYC, default 120_000_000, side-road green time in cycles.
REQ-003 SHALL have parameter BLUE_CYC, default 48_000_000, blue (caution) time in cycles.
REQ-004 SHALL have parameter ALLRED_CYC, default 24_000_000, all-red clearance time in cycles.
REQ-005 SHALL have parameter PED_CYC, default 240_000_000, pedestrian walk time in cycles.
REQ-006 SHALL have port clk, input, 1, the single system clock.
REQ-007 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-008 SHALL have port side_req, input, 1, side-road vehicle sensor (level).
REQ-009 SHALL have port ped_req, input, 1, pedestrian button (any-length pulse).
REQ-010 SHALL have port ped_ack, output, 1, one-cycle pulse acknowledging a latched pedestrian request.
REQ-011 SHALL have port main_led, output, 3, main-road lamps, active-low {R,B,G}.
REQ-012 SHALL have port side_led, output, 3, side-road lamps, active-low {R,B,G}.
REQ-013 SHALL have port ped_walk, output, 1, pedestrian walk lamp, active-high.
REQ-014 SHALL have port phase, output, 3, current FSM state encoding (debug).

Function
REQ-015 SHALL encode lamps as red 3'b011, blue 3'b101, green 3'b110; every output is registered.
REQ-016 SHALL implement states STARTUP, MAIN_G, MAIN_B, CLR_A, SIDE_G, SIDE_B, CLR_B, PED, CLR_C.
REQ-017 SHALL load a cycle timer on state entry so each timed state lasts exactly its parameter value in cycles; every parameter is at least 1.
REQ-018 SHALL transition STARTUP->MAIN_G after ALLRED_CYC cycles.
REQ-019 SHALL hold MAIN_G at least MAIN_GREEN_CYC cycles, then exit to MAIN_B in the first cycle with side_req high or ped pending; with neither, MAIN_G is held indefinitely.
REQ-020 SHALL sequence MAIN_B (BLUE_CYC) -> CLR_A (ALLRED_CYC) -> SIDE_G if side latch set, else PED if ped pending, else MAIN_G.
REQ-021 SHALL sequence SIDE_G (SIDE_GREEN_CYC) -> SIDE_B (BLUE_CYC) -> CLR_B (ALLRED_CYC) -> PED if ped pending, else MAIN_G.
REQ-022 SHALL sequence PED (PED_CYC) -> CLR_C (ALLRED_CYC) -> MAIN_G.
REQ-023 SHALL latch side_req when MAIN_B is entered and clear the latch when SIDE_G is entered.
REQ-024 SHALL set ped pending on a ped_req rising edge, pulse ped_ack the following cycle, and clear pending on PED entry; a rising edge in the PED-entry cycle wins (stays pending).
REQ-025 SHALL drive lamps in non-green phases as follows: side_led red in MAIN_*; main_led red in SIDE_*; both red in STARTUP/CLR_*/PED; ped_walk high only in PED.
REQ-026 SHALL never show non-red on both roads in the same cycle.

Reset
REQ-027 SHALL, while rst_n is low at a clk edge, enter STARTUP, set main_led=side_led=3'b011, ped_walk=0, ped_ack=0, clear all latches and the timer, including mid-phase.

Configuration
REQ-028 SHALL, with TRAFFIC_PED_EN defined, include the PED/CLR_C states and the pedestrian logic as specified.
REQ-029 SHALL, without TRAFFIC_PED_EN, ignore ped_req, tie ped_walk and ped_ack to 0, omit PED/CLR_C, and exit MAIN_G only on side_req.

Structure
REQ-030 SHALL take lamp constants (LED_RED, LED_BLUE, LED_GREEN) and the state enum from shared package traffic_pkg.
REQ-031 SHALL instantiate sub-module phase_timer (loadable 32-bit down counter with done flag).

Verification (MAIN_GREEN_CYC=8, SIDE_GREEN_CYC=6, BLUE_CYC=3, ALLRED_CYC=2, PED_CYC=5)
REQ-032 SHALL cover: rst_n low 3 cycles then high -> leds 011/011 for 2 cycles, then main_led=110.
REQ-033 SHALL cover: no requests for 100 cycles -> main_led=110, side_led=011 throughout.
REQ-034 SHALL cover: side_req held high -> main green 8, main blue 3, all-red 2, side green 6, side blue 3, all-red 2, main green.
REQ-035 SHALL cover: 1-cycle ped_req in MAIN_G -> ped_ack next cycle; after blue 3 + all-red 2, ped_walk=1 for 5 cycles with both leds 011, all-red 2, main green.
REQ-036 SHALL cover: side_req and ped_req together -> side phase served first, then PED, then MAIN_G.
REQ-037 SHALL cover: rst_n low in SIDE_G -> next cycle both leds 011, ped_walk=0, latches cleared, STARTUP.
